// File: rtl/execute_mc.sv
// LEGv8 execute stage: forwarding muxes, single-cycle ALU, branch target adder
// and an iterative shift-add multiplier that stalls the front of the pipeline.
module execute_mc #(
    parameter int N        = 64,
    parameter int MUL_BITS = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_E,
    input  logic         flush_E,
    input  logic         AluSrc,
    input  logic [3:0]   AluControl,
    input  logic [1:0]   forwardA,
    input  logic [1:0]   forwardB,
    input  logic [N-1:0] PC_E,
    input  logic [N-1:0] signImm_E,
    input  logic [N-1:0] readData1_E,
    input  logic [N-1:0] readData2_E,
    input  logic [N-1:0] aluResult_M,
    input  logic [N-1:0] writeData_W,
    output logic [N-1:0] PCBranch_E,
    output logic [N-1:0] aluResult_E,
    output logic [N-1:0] writeData_E,
    output logic         zero_E,
    output logic         stall_E
);

    localparam int K  = N / MUL_BITS;
    localparam int CW = $clog2(K + 1);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_PASS = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_MUL  = 4'b1000;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_next;
    logic [N-1:0]  acc, mcand, mplier;
    logic [CW-1:0] cnt;
    logic [N-1:0]  op_a, op_bf, op_b, alu_comb, partial;
    logic          issue;

    always_comb begin
        case (forwardA)
            2'b01:   op_a = writeData_W;
            2'b10:   op_a = aluResult_M;
            default: op_a = readData1_E;
        endcase
        case (forwardB)
            2'b01:   op_bf = writeData_W;
            2'b10:   op_bf = aluResult_M;
            default: op_bf = readData2_E;
        endcase
        op_b = AluSrc ? signImm_E : op_bf;
    end

    assign writeData_E = op_bf;
    assign PCBranch_E  = PC_E + (signImm_E << 2);

    always_comb begin
        case (AluControl)
            ALU_AND:  alu_comb = op_a & op_b;
            ALU_OR:   alu_comb = op_a | op_b;
            ALU_ADD:  alu_comb = op_a + op_b;
            ALU_SUB:  alu_comb = op_a - op_b;
            ALU_PASS: alu_comb = op_b;
            ALU_NOR:  alu_comb = ~(op_a | op_b);
            default:  alu_comb = '0;
        endcase
    end

    // One radix-2^MUL_BITS digit of the product per BUSY cycle.
    always_comb begin
        partial = '0;
        for (int j = 0; j < MUL_BITS; j++) begin
            if (mplier[j]) partial = partial + (mcand << j);
        end
    end

    always_comb begin
        state_next = state;
        stall_E    = 1'b0;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (valid_E && AluControl == ALU_MUL && !flush_E) begin
                    issue      = 1'b1;
                    stall_E    = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (flush_E) begin
                    state_next = IDLE;
                end else begin
                    stall_E = 1'b1;
                    if (cnt == CW'(K - 1)) state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Stall must drop the moment reset is asserted, even with a MUL waiting.
        if (!reset) stall_E = 1'b0;
    end

    assign aluResult_E = (state == DONE) ? acc : alu_comb;
    assign zero_E      = (aluResult_E == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (issue) begin
                        mcand  <= op_a;
                        mplier <= op_b;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    if (flush_E) begin
                        acc <= '0;
                    end else begin
                        acc    <= acc + partial;
                        mcand  <= mcand << MUL_BITS;
                        mplier <= mplier >> MUL_BITS;
                        cnt    <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (flush_E) acc <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_mc.sv
// Directed self-checking bench for execute_mc; one instance per multiplier radix.
module tb_execute_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid1, valid4;
    logic        flush_E;
    logic        AluSrc;
    logic [3:0]  AluControl;
    logic [1:0]  forwardA, forwardB;
    logic [63:0] PC_E, signImm_E, readData1_E, readData2_E, aluResult_M, writeData_W;

    logic [63:0] pcb1, res1, wd1, pcb4, res4, wd4;
    logic        zero1, stall1, zero4, stall4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    execute_mc #(.N(64), .MUL_BITS(1)) dut1 (
        .clk(clk), .reset(reset), .valid_E(valid1), .flush_E(flush_E),
        .AluSrc(AluSrc), .AluControl(AluControl),
        .forwardA(forwardA), .forwardB(forwardB),
        .PC_E(PC_E), .signImm_E(signImm_E),
        .readData1_E(readData1_E), .readData2_E(readData2_E),
        .aluResult_M(aluResult_M), .writeData_W(writeData_W),
        .PCBranch_E(pcb1), .aluResult_E(res1), .writeData_E(wd1),
        .zero_E(zero1), .stall_E(stall1)
    );

    execute_mc #(.N(64), .MUL_BITS(4)) dut4 (
        .clk(clk), .reset(reset), .valid_E(valid4), .flush_E(flush_E),
        .AluSrc(AluSrc), .AluControl(AluControl),
        .forwardA(forwardA), .forwardB(forwardB),
        .PC_E(PC_E), .signImm_E(signImm_E),
        .readData1_E(readData1_E), .readData2_E(readData2_E),
        .aluResult_M(aluResult_M), .writeData_W(writeData_W),
        .PCBranch_E(pcb4), .aluResult_E(res4), .writeData_E(wd4),
        .zero_E(zero4), .stall_E(stall4)
    );

    task automatic drive_idle();
        valid1 = 1'b0; valid4 = 1'b0; flush_E = 1'b0; AluSrc = 1'b0;
        AluControl = 4'b0010; forwardA = 2'b00; forwardB = 2'b00;
        PC_E = '0; signImm_E = '0; readData1_E = '0; readData2_E = '0;
        aluResult_M = '0; writeData_W = '0;
    endtask

    // Counts consecutive stalled negedges; leaves time at the first unstalled negedge.
    task automatic measure_stall(input bit wide, output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((wide ? stall4 : stall1) === 1'b1) n++;
            else break;
        end
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b0;
        readData1_E = 64'h20; readData2_E = 64'h3;
        #2;
        checks++; if (stall1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall1: got %b expected 0", stall1); end
        checks++; if (stall4 !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall4: got %b expected 0", stall4); end
        checks++; if (res1 !== 64'h23) begin errors++; $display("[TB] FAIL reset_comb: got %h expected %h", res1, 64'h23); end
        AluControl = 4'b1000; valid1 = 1'b1;
        #1;
        checks++; if (stall1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_mul_stall: got %b expected 0", stall1); end
        valid1 = 1'b0; AluControl = 4'b0010;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_add();
        @(posedge clk); #1;
        forwardA = 2'b10; aluResult_M = 64'h10; readData1_E = 64'hDEAD;
        readData2_E = 64'h5; AluSrc = 1'b0; AluControl = 4'b0010;
        @(negedge clk);
        checks++; if (res1 !== 64'h15) begin errors++; $display("[TB] FAIL add_fwdM: got %h expected %h", res1, 64'h15); end
        checks++; if (zero1 !== 1'b0) begin errors++; $display("[TB] FAIL add_zero: got %b expected 0", zero1); end
        checks++; if (stall1 !== 1'b0) begin errors++; $display("[TB] FAIL add_stall: got %b expected 0", stall1); end
        checks++; if (wd1 !== 64'h5) begin errors++; $display("[TB] FAIL add_wd: got %h expected %h", wd1, 64'h5); end
        forwardB = 2'b01; writeData_W = 64'h99;
        #1;
        checks++; if (wd1 !== 64'h99) begin errors++; $display("[TB] FAIL fwdW_wd: got %h expected %h", wd1, 64'h99); end
        checks++; if (res4 !== 64'hA9) begin errors++; $display("[TB] FAIL fwdW_add: got %h expected %h", res4, 64'hA9); end
        forwardA = 2'b11; forwardB = 2'b11;
        #1;
        checks++; if (res1 !== 64'hDEB2) begin errors++; $display("[TB] FAIL fwd11_add: got %h expected %h", res1, 64'hDEB2); end
        drive_idle();
    endtask

    task automatic test_logic_and_branch();
        @(posedge clk); #1;
        readData1_E = 64'h7; readData2_E = 64'h7; AluControl = 4'b0110;
        PC_E = 64'h100; signImm_E = 64'h4;
        @(negedge clk);
        checks++; if (res1 !== 64'h0) begin errors++; $display("[TB] FAIL sub_res: got %h expected 0", res1); end
        checks++; if (zero1 !== 1'b1) begin errors++; $display("[TB] FAIL sub_zero: got %b expected 1", zero1); end
        checks++; if (pcb1 !== 64'h110) begin errors++; $display("[TB] FAIL pcbranch: got %h expected %h", pcb1, 64'h110); end
        AluControl = 4'b1100;
        #1;
        checks++; if (res1 !== 64'hFFFF_FFFF_FFFF_FFF8) begin errors++; $display("[TB] FAIL nor_res: got %h expected %h", res1, 64'hFFFF_FFFF_FFFF_FFF8); end
        AluControl = 4'b0111; AluSrc = 1'b1;
        #1;
        checks++; if (res1 !== 64'h4) begin errors++; $display("[TB] FAIL passb_imm: got %h expected 4", res1); end
        AluControl = 4'b0001; readData1_E = 64'h3;
        #1;
        checks++; if (res1 !== 64'h7) begin errors++; $display("[TB] FAIL or_imm: got %h expected 7", res1); end
        AluControl = 4'b0011;
        #1;
        checks++; if (res1 !== 64'h0 || zero1 !== 1'b1) begin errors++; $display("[TB] FAIL undef_op: got %h/%b expected 0/1", res1, zero1); end
        drive_idle();
    endtask

    task automatic test_mul_radix1();
        int n;
        @(posedge clk); #1;
        readData1_E = 64'd3; readData2_E = 64'd5; AluControl = 4'b1000; valid1 = 1'b1;
        measure_stall(1'b0, n);
        checks++; if (n != 65) begin errors++; $display("[TB] FAIL mul1_stalls: got %0d expected 65", n); end
        checks++; if (res1 !== 64'd15) begin errors++; $display("[TB] FAIL mul1_prod: got %h expected %h", res1, 64'd15); end
        valid1 = 1'b0; AluControl = 4'b0010;
        @(negedge clk);
        checks++; if (stall1 !== 1'b0 || res1 !== 64'd8) begin errors++; $display("[TB] FAIL mul1_idle: got %b/%h expected 0/%h", stall1, res1, 64'd8); end
        drive_idle();
    endtask

    task automatic test_mul_radix4();
        int n;
        @(posedge clk); #1;
        readData1_E = 64'hFFFF_FFFF_FFFF_FFFF; readData2_E = 64'd7; AluControl = 4'b1000; valid4 = 1'b1;
        measure_stall(1'b1, n);
        checks++; if (n != 17) begin errors++; $display("[TB] FAIL mul4_stalls: got %0d expected 17", n); end
        checks++; if (res4 !== 64'hFFFF_FFFF_FFFF_FFF9) begin errors++; $display("[TB] FAIL mul4_prod: got %h expected %h", res4, 64'hFFFF_FFFF_FFFF_FFF9); end
        checks++; if (zero4 !== 1'b0) begin errors++; $display("[TB] FAIL mul4_zero: got %b expected 0", zero4); end
        valid4 = 1'b0;
        @(posedge clk); #1;
        readData1_E = 64'd123; readData2_E = 64'd0; valid4 = 1'b1;
        measure_stall(1'b1, n);
        checks++; if (n != 17) begin errors++; $display("[TB] FAIL mul4z_stalls: got %0d expected 17", n); end
        checks++; if (res4 !== 64'd0 || zero4 !== 1'b1) begin errors++; $display("[TB] FAIL mul4z_prod: got %h/%b expected 0/1", res4, zero4); end
        drive_idle();
    endtask

    task automatic test_flush();
        @(posedge clk); #1;
        readData1_E = 64'd3; readData2_E = 64'd5; AluControl = 4'b1000; valid1 = 1'b1; flush_E = 1'b1;
        @(negedge clk);
        checks++; if (stall1 !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle_block: got %b expected 0", stall1); end
        flush_E = 1'b0; valid1 = 1'b0;
        @(posedge clk); #1;
        valid1 = 1'b1;
        repeat (9) @(posedge clk);
        @(negedge clk);
        checks++; if (stall1 !== 1'b1) begin errors++; $display("[TB] FAIL flush_busy: got %b expected 1", stall1); end
        @(posedge clk); #1;
        flush_E = 1'b1; valid1 = 1'b0;
        @(negedge clk);
        checks++; if (stall1 !== 1'b0) begin errors++; $display("[TB] FAIL flush_cycle: got %b expected 0", stall1); end
        @(posedge clk); #1;
        flush_E = 1'b0; AluControl = 4'b0010;
        @(negedge clk);
        checks++; if (stall1 !== 1'b0 || res1 !== 64'd8) begin errors++; $display("[TB] FAIL flush_after: got %b/%h expected 0/%h", stall1, res1, 64'd8); end
        drive_idle();
    endtask

    task automatic test_reset_mid_mul();
        int n;
        @(posedge clk); #1;
        readData1_E = 64'd3; readData2_E = 64'd5; AluControl = 4'b1000; valid1 = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++; if (stall1 !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_stall: got %b expected 0", stall1); end
        valid1 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        forwardA = 2'b10; aluResult_M = 64'd2; readData2_E = 64'd2; valid1 = 1'b1;
        @(posedge clk); #1;
        aluResult_M = 64'd9;
        measure_stall(1'b0, n);
        checks++; if (n != 64) begin errors++; $display("[TB] FAIL rst_mul_stalls: got %0d expected 64", n); end
        checks++; if (res1 !== 64'd4) begin errors++; $display("[TB] FAIL rst_mul_prod: got %h expected 4", res1); end
        drive_idle();
    endtask

    task automatic test_back_to_back();
        int n;
        @(posedge clk); #1;
        readData1_E = 64'd6; readData2_E = 64'd7; AluControl = 4'b1000; valid1 = 1'b1;
        measure_stall(1'b0, n);
        checks++; if (n != 65) begin errors++; $display("[TB] FAIL b2b_first_stalls: got %0d expected 65", n); end
        checks++; if (res1 !== 64'd42 || stall1 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_first_prod: got %h/%b expected %h/0", res1, stall1, 64'd42); end
        readData1_E = 64'd3; readData2_E = 64'd3;
        measure_stall(1'b0, n);
        checks++; if (n != 65) begin errors++; $display("[TB] FAIL b2b_second_stalls: got %0d expected 65", n); end
        checks++; if (res1 !== 64'd9 || stall1 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_second_prod: got %h/%b expected 9/0", res1, stall1); end
        valid1 = 1'b0;
        drive_idle();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_add();
        test_logic_and_branch();
        test_mul_radix1();
        test_mul_radix4();
        test_flush();
        test_reset_mid_mul();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/execute_mc.md
# execute_mc

Parametrised execute stage for the pipelined LEGv8 datapath with a multi-cycle multiplier. It sits between the ID/EX and EX/MEM pipeline registers. It adds three things to the single-cycle execute function: operand forwarding muxes, an iterative shift-add multiplier, and a stall/flush handshake with the hazard unit. Single-cycle ALU operations complete combinationally. MUL freezes the front of the pipeline until its product is ready.

## Interface
- N, 64, datapath width in bits
- MUL_BITS, 1, multiplier bits consumed per iteration; legal values are 1, 2, 4, 8, and the value must divide N
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- valid_E  in  1  the ID/EX register holds a real instruction
- flush_E  in  1  kill the instruction in EX (branch taken or exception)
- AluSrc  in  1  B operand select: 0 = forwarded readData2_E, 1 = signImm_E
- AluControl  in  4  operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 pass B, 1100 NOR, 1000 MUL; all other codes produce 0
- forwardA, forwardB  in  2 each  forwarding select: 00 register file, 01 writeData_W, 10 aluResult_M, 11 register file
- PC_E, signImm_E, readData1_E, readData2_E  in  N each  ID/EX register contents
- aluResult_M, writeData_W  in  N each  forwarding sources from the MEM and WB stages
- PCBranch_E  out  N  PC_E + (signImm_E << 2), modulo 2^N
- aluResult_E  out  N  ALU result or product
- writeData_E  out  N  forwarded B operand, taken before the AluSrc mux
- zero_E  out  1  aluResult_E == 0
- stall_E  out  1  freeze PC, IF/ID and ID/EX; insert a bubble into EX/MEM

## Operation
- Operand path: A = fwd(readData1_E, forwardA). Bf = fwd(readData2_E, forwardB). B = AluSrc ? signImm_E : Bf. writeData_E = Bf.
- Arithmetic: ADD and SUB wrap modulo 2^N. MUL returns the low N bits of A*B; two's-complement and unsigned low halves are identical, so there is no separate signed mode.
- FSM states:
  - IDLE
    - Non-MUL operation: combinational result, stall_E = 0.
    - valid_E=1, AluControl=1000, flush_E=0: latch mcand=A, mplier=B, acc=0, cnt=0; stall_E=1 this cycle; next state BUSY.
  - BUSY
    - Each cycle: acc += (mcand * mplier[MUL_BITS-1:0]); mcand <<= MUL_BITS; mplier >>= MUL_BITS; cnt++.
    - stall_E=1 throughout.
    - When cnt reaches K-1 (K = N/MUL_BITS), go to DONE.
  - DONE
    - aluResult_E = acc; zero_E = (acc == 0); stall_E = 0, so the pipeline advances and EX/MEM captures the product.
    - Next state IDLE unconditionally. The same MUL is never re-issued, even though its inputs are still present in this cycle.
- Flush: flush_E=1 in BUSY or DONE forces IDLE on the next edge, discards acc, and stall_E=0 in that cycle. flush_E=1 in IDLE blocks issue.
- Reset (reset=0, asynchronous): state=IDLE, acc=0, mcand=0, mplier=0, cnt=0, stall_E=0. Combinational outputs follow the inputs. Reset asserted mid-multiply abandons it with no result.
- While the FSM is not in DONE, aluResult_E and zero_E show the combinational ALU result for the current inputs. Consumers ignore them while stall_E=1.
- Operands are latched at issue. Changes on aluResult_M or writeData_W during BUSY do not affect the product.

## Timing
- Non-MUL latency: 0 cycles (combinational).
- MUL issued in cycle t:
  - stall_E=1 in cycles t through t+K.
  - Product is valid in cycle t+K+1, the DONE cycle, with stall_E=0.
  - Total EX occupancy is K+2 cycles (66 cycles for N=64, MUL_BITS=1).
- Back-to-back MULs: the second MUL enters EX in the cycle after DONE and issues from IDLE. There are no dead cycles beyond the DONE cycle.
- Upstream holds all inputs of this block stable while stall_E=1. The block does not rely on this for the operands, only for AluControl and valid_E.
- PCBranch_E is purely combinational and does not depend on the FSM state.

## Test plan
- ADD with forwardA=10 (aluResult_M=0x10) and readData2_E=0x5, AluSrc=0 -> aluResult_E=0x15, zero_E=0, stall_E=0.
- SUB 7-7 with AluSrc=0 -> aluResult_E=0, zero_E=1. PC_E=0x100, signImm_E=4 -> PCBranch_E=0x110.
- MUL 3*5 at N=64, MUL_BITS=1 -> stall_E high for exactly 65 cycles; the next cycle shows aluResult_E=15 with stall_E=0; the FSM is in IDLE one cycle later.
- MUL 0xFFFF_FFFF_FFFF_FFFF * 7 at MUL_BITS=4 -> after 17 stall cycles, aluResult_E=0xFFFF_FFFF_FFFF_FFF9. MUL by 0 -> zero_E=1 in DONE.
- flush_E pulsed 10 cycles into a MUL -> stall_E=0 in the flush cycle and afterwards, and the FSM returns to IDLE. Then reset=0 pulsed mid-MUL -> stall_E drops immediately, and a subsequent MUL 2*2 yields 4.
- Two consecutive MULs (6*7 then 3*3) -> products 42 and 9, each in its own DONE cycle; stall_E low for exactly one cycle between the two stall windows.
